// File: rtl/hazard_controller_if.sv
// Pipeline hazard control bundle: ID/EX/MEM status in, register
// enables, flushes and FSM status out.
interface hazard_controller_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_flush;
    logic       ex_mem_en;
    logic       mem_wb_en;
    logic       hazard_err;
    logic [1:0] fsm_state;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_mem_read, ex_rd, ex_branch_taken,
        output mem_req, mem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_en,
        input  id_ex_flush, ex_mem_en, mem_wb_en,
        input  hazard_err, fsm_state
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_mem_read, ex_rd, ex_branch_taken,
        input  mem_req, mem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_en,
        output id_ex_flush, ex_mem_en, mem_wb_en,
        output hazard_err, fsm_state
    );
endinterface

// File: rtl/hazard_controller.sv
// 5-stage pipeline hazard controller: load-use, branch flush, memory wait.
// Optional performance counters enabled by HAZARD_PERF_CNT_EN.
module hazard_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic clk,
    input  logic rst,
    hazard_controller_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] mem_wait_cycles
`endif
);

    if (TIMEOUT < 1 || TIMEOUT > 255 || CNT_W < 1) begin : g_bad_cfg
        $error("hazard_controller: TIMEOUT or CNT_W out of range");
    end

    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       err_q, err_nxt;

    logic mem_stall;
    logic load_use;
    logic frz;
    logic rs1_hit, rs2_hit;

    logic pc_en, if_id_en, if_id_flush, id_ex_en;
    logic id_ex_flush, ex_mem_en, mem_wb_en;

    assign mem_stall = hz.mem_req & ~hz.mem_ready;
    assign rs1_hit   = hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd);
    assign rs2_hit   = hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd);
    assign load_use  = hz.ex_mem_read & (hz.ex_rd != 5'd0)
                     & (rs1_hit | rs2_hit);
    assign frz       = (state == ERROR) | mem_stall;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = err_q;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == TO) begin
                    state_nxt = ERROR;
                    err_nxt   = 1'b1;
                end else if (wait_cnt != 8'hFF) begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            err_q    <= err_nxt;
        end
    end

    // Decode terms are made mutually exclusive to encode priority.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        unique case (1'b1)
            rst: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                if_id_flush = 1'b1;
                id_ex_en    = 1'b0;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b0;
                mem_wb_en   = 1'b0;
            end
            (!rst && frz): begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
            end
            (!rst && !frz && hz.ex_branch_taken): begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            (!rst && !frz && !hz.ex_branch_taken && load_use): begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign hz.pc_en       = pc_en;
    assign hz.if_id_en    = if_id_en;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_en    = id_ex_en;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.ex_mem_en   = ex_mem_en;
    assign hz.mem_wb_en   = mem_wb_en;
    assign hz.hazard_err  = err_q;
    assign hz.fsm_state   = state;

`ifdef HAZARD_PERF_CNT_EN
    logic cnt_stall, cnt_flush, cnt_wait;

    assign cnt_stall = !frz && !hz.ex_branch_taken && load_use;
    assign cnt_flush = !frz && hz.ex_branch_taken;
    assign cnt_wait  = (state != ERROR) && mem_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles    <= '0;
            flush_count     <= '0;
            mem_wait_cycles <= '0;
        end else begin
            if (cnt_stall) stall_cycles    <= stall_cycles + 1'b1;
            if (cnt_flush) flush_count     <= flush_count + 1'b1;
            if (cnt_wait)  mem_wait_cycles <= mem_wait_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed hazards plus
// randomized traffic against a rule-level reference model.
module tb_hazard_controller;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_controller_if hz();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc, fc, mw;
    int unsigned m_sc, m_fc, m_mw;
`endif

    hazard_controller #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles    (sc),
        .flush_count     (fc),
        .mem_wait_cycles (mw)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: count of consecutive stalled cycles, plus sticky error flag.
    int m_n   = 0;
    bit m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_stall();
        return hz.mem_req && !hz.mem_ready;
    endfunction

    function automatic bit m_lu();
        bit hit;
        hit = (hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) ||
              (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd);
        return hz.ex_mem_read && hz.ex_rd != 5'd0 && hit;
    endfunction

    // {pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem, mem_wb}
    function automatic logic [6:0] exp_ctl();
        if (rst)                   return 7'b0010100;
        if (m_err || m_stall())    return 7'b0000000;
        if (hz.ex_branch_taken)    return 7'b1111111;
        if (m_lu())                return 7'b0001111;
        return 7'b1101011;
    endfunction

    function automatic logic [6:0] obs_ctl();
        return {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en,
                hz.id_ex_flush, hz.ex_mem_en, hz.mem_wb_en};
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_err) return 2'b10;
        return (m_n > 0) ? 2'b01 : 2'b00;
    endfunction

    task automatic drive(input bit br, input bit mr, input int rd,
                         input int rs1, input bit u1, input int rs2,
                         input bit u2, input bit req, input bit rdy);
        hz.ex_branch_taken = br;
        hz.ex_mem_read     = mr;
        hz.ex_rd           = 5'(rd);
        hz.id_rs1          = 5'(rs1);
        hz.id_uses_rs1     = u1;
        hz.id_rs2          = 5'(rs2);
        hz.id_uses_rs2     = u2;
        hz.mem_req         = req;
        hz.mem_ready       = rdy;
    endtask

    task automatic step(input string tag);
        #1;
        check({tag, ".ctl"}, 32'(obs_ctl()), 32'(exp_ctl()));
        check({tag, ".state"}, 32'(hz.fsm_state), 32'(exp_state()));
        check({tag, ".err"}, 32'(hz.hazard_err), 32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
        check({tag, ".stall_cnt"}, sc, m_sc);
        check({tag, ".flush_cnt"}, fc, m_fc);
        check({tag, ".wait_cnt"}, mw, m_mw);
`endif
        @(posedge clk);
        if (!m_err) begin
`ifdef HAZARD_PERF_CNT_EN
            if (m_stall())                m_mw++;
            else if (hz.ex_branch_taken)  m_fc++;
            else if (m_lu())              m_sc++;
`endif
            if (m_stall()) begin
                if (m_n == TO) m_err = 1'b1;
                else m_n++;
            end else begin
                m_n = 0;
            end
        end
        @(negedge clk);
    endtask

    // Asserted between edges so the clear must be asynchronous.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        m_n   = 0;
        m_err = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
        m_sc = 0;
        m_fc = 0;
        m_mw = 0;
`endif
        check({tag, ".rst_ctl"}, 32'(obs_ctl()), 32'(exp_ctl()));
        check({tag, ".rst_state"}, 32'(hz.fsm_state), 32'd0);
        check({tag, ".rst_err"}, 32'(hz.hazard_err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset("init");
        step("idle");

        drive(0, 1, 5, 1, 1, 5, 1, 0, 0);
        step("lu_stall");
        drive(0, 0, 0, 1, 1, 5, 1, 0, 0);
        step("lu_bubble");

        drive(0, 1, 0, 0, 1, 3, 0, 0, 0);
        step("x0_rd");
        drive(0, 1, 7, 2, 1, 7, 0, 0, 0);
        step("rs2_unused");
        drive(0, 1, 9, 9, 1, 0, 0, 0, 0);
        step("lu_rs1");

        drive(1, 1, 5, 5, 1, 0, 0, 0, 0);
        step("br_over_lu");

        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            step("mwait");
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("mwait_rel");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("single_acc");

        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
            step("br_in_wait");
        end
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
        step("br_rel");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("after_br");

        for (int i = 0; i < TO + 1; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            step("timeout");
        end
        drive(1, 1, 5, 5, 1, 0, 0, 0, 0);
        step("err_frozen");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("err_frozen2");
        do_reset("err_rst");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("post_rst");

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 5) == 0),
                  $urandom_range(0, 1),
                  $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 1),
                  ($urandom_range(0, 2) != 0));
            step("rand");
            if (m_err && $urandom_range(0, 3) == 0) do_reset("rand_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
